// File: rtl/video_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : video_input_framer
// Description : Source-domain front end for the upscaler write side. Registers
//               raw video, finds line/frame boundaries from sync falling
//               edges, issues line-buffer writes and tracks timing lock.
// Revision    : 1.0 - initial release
// ============================================================================
module video_input_framer #(
    parameter int C_COMPONENT_DEPTH   = 8,
    parameter int C_X_WIDTH           = 11,
    parameter int C_Y_WIDTH           = 10,
    parameter int C_INDEX_WIDTH       = 3,
    parameter int C_LINE_BUFFER_COUNT = 8,
    parameter int C_LOCK_FRAMES       = 2
) (
    input  logic                         pixel_clk_a,
    input  logic                         rst,
    input  logic                         hsync_a,
    input  logic                         vsync_a,
    input  logic                         hblank_a,
    input  logic                         vblank_a,
    input  logic [C_COMPONENT_DEPTH-1:0] red_a,
    input  logic [C_COMPONENT_DEPTH-1:0] green_a,
    input  logic [C_COMPONENT_DEPTH-1:0] blue_a,
    output logic                         wr_en,
    output logic [C_X_WIDTH-1:0]         wr_x,
    output logic [C_INDEX_WIDTH-1:0]     wr_index,
    output logic [C_COMPONENT_DEPTH-1:0] wr_red,
    output logic [C_COMPONENT_DEPTH-1:0] wr_green,
    output logic [C_COMPONENT_DEPTH-1:0] wr_blue,
    output logic                         line_done,
    output logic [C_X_WIDTH-1:0]         line_width,
    output logic                         frame_done,
    output logic [C_Y_WIDTH-1:0]         frame_height,
    output logic                         locked,
    output logic                         width_overflow
);

    localparam logic [C_X_WIDTH-1:0]     C_X_MAX        = {C_X_WIDTH{1'b1}};
    localparam logic [C_Y_WIDTH-1:0]     C_Y_MAX        = {C_Y_WIDTH{1'b1}};
    localparam logic [C_INDEX_WIDTH-1:0] C_INDEX_LAST   = C_INDEX_WIDTH'(C_LINE_BUFFER_COUNT - 1);
    localparam int                       C_MATCH_WIDTH  = (C_LOCK_FRAMES < 2) ? 1 : $clog2(C_LOCK_FRAMES + 1);
    localparam logic [C_MATCH_WIDTH-1:0] C_MATCH_TARGET = C_MATCH_WIDTH'(C_LOCK_FRAMES);
    localparam logic [C_MATCH_WIDTH-1:0] C_MATCH_ONE    = C_MATCH_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Stage-1 input registers and sync history
    logic                         hsync_s1_d, hsync_s1_q, vsync_s1_d, vsync_s1_q;
    logic                         hblank_s1_d, hblank_s1_q, vblank_s1_d, vblank_s1_q;
    logic [C_COMPONENT_DEPTH-1:0] red_s1_d, red_s1_q, green_s1_d, green_s1_q, blue_s1_d, blue_s1_q;
    logic                         hsync_hist_d, hsync_hist_q, vsync_hist_d, vsync_hist_q;
    // Line / frame tracking
    logic [C_X_WIDTH-1:0]         x_d, x_q;
    logic [C_Y_WIDTH-1:0]         line_cnt_d, line_cnt_q;
    logic [C_INDEX_WIDTH-1:0]     index_d, index_q;
    logic                         index_rst_pend_d, index_rst_pend_q;
    logic [C_X_WIDTH-1:0]         ref_width_d, ref_width_q;
    logic                         ref_valid_d, ref_valid_q, inconsistent_d, inconsistent_q;
    logic [C_X_WIDTH-1:0]         frame_width_d, frame_width_q;
    logic                         frame_consistent_d, frame_consistent_q;
    // Lock FSM
    state_t                       state_d, state_q;
    logic [C_MATCH_WIDTH-1:0]     match_cnt_d, match_cnt_q;
    logic [C_X_WIDTH-1:0]         stored_width_d, stored_width_q;
    logic [C_Y_WIDTH-1:0]         stored_height_d, stored_height_q;
    // Stage-2 output registers
    logic                         wr_en_d, wr_en_q;
    logic [C_X_WIDTH-1:0]         wr_x_d, wr_x_q;
    logic [C_INDEX_WIDTH-1:0]     wr_index_d, wr_index_q;
    logic [C_COMPONENT_DEPTH-1:0] wr_red_d, wr_red_q, wr_green_d, wr_green_q, wr_blue_d, wr_blue_q;
    logic                         line_done_d, line_done_q, frame_done_d, frame_done_q;
    logic [C_X_WIDTH-1:0]         line_width_d, line_width_q;
    logic [C_Y_WIDTH-1:0]         frame_height_d, frame_height_q;
    logic                         locked_d, locked_q, width_overflow_d, width_overflow_q;

    // Combinational helpers
    logic                         h_fall, v_fall, pix_active, line_close, x_full, pix_write;
    logic [C_X_WIDTH-1:0]         x_base;
    logic [C_INDEX_WIDTH-1:0]     index_next, index_eff;
    logic [C_Y_WIDTH-1:0]         line_cnt_eff;
    logic                         ref_valid_eff, inconsistent_eff, frame_ok, frame_match;
    logic [C_X_WIDTH-1:0]         ref_width_eff;
    logic [C_MATCH_WIDTH-1:0]     match_inc;

    // A line closes before any pixel in the same cycle, so that pixel starts the new line at x=0
    assign h_fall       = hsync_hist_q & ~hsync_s1_q;
    assign v_fall       = vsync_hist_q & ~vsync_s1_q;
    assign pix_active   = ~hblank_s1_q & ~vblank_s1_q;
    assign line_close   = h_fall && (x_q != '0);
    assign x_base       = h_fall ? '0 : x_q;
    assign x_full       = (x_base == C_X_MAX);
    assign pix_write    = pix_active && !x_full;
    assign index_next   = (index_q == C_INDEX_LAST) ? '0 : index_q + C_INDEX_WIDTH'(1);
    assign index_eff    = line_close ? index_next : (index_rst_pend_q ? '0 : index_q);
    assign line_cnt_eff = (line_close && line_cnt_q != C_Y_MAX) ? line_cnt_q + C_Y_WIDTH'(1) : line_cnt_q;

    // Width reference: first non-empty line of the frame; any other width taints the frame
    always_comb begin
        ref_valid_eff    = ref_valid_q;
        ref_width_eff    = ref_width_q;
        inconsistent_eff = inconsistent_q;
        if (line_close) begin
            if (!ref_valid_q) begin
                ref_valid_eff = 1'b1;
                ref_width_eff = x_q;
            end else if (x_q != ref_width_q) begin
                inconsistent_eff = 1'b1;
            end
        end
    end

    // Datapath next state: input capture, counters, frame close and write outputs
    always_comb begin
        hsync_s1_d         = hsync_a;
        vsync_s1_d         = vsync_a;
        hblank_s1_d        = hblank_a;
        vblank_s1_d        = vblank_a;
        red_s1_d           = red_a;
        green_s1_d         = green_a;
        blue_s1_d          = blue_a;
        hsync_hist_d       = hsync_s1_q;
        vsync_hist_d       = vsync_s1_q;

        x_d                = pix_write ? x_base + C_X_WIDTH'(1) : x_base;
        index_d            = index_eff;
        line_cnt_d         = line_cnt_eff;
        ref_valid_d        = ref_valid_eff;
        ref_width_d        = ref_width_eff;
        inconsistent_d     = inconsistent_eff;
        frame_width_d      = frame_width_q;
        frame_consistent_d = frame_consistent_q;
        frame_height_d     = frame_height_q;
        index_rst_pend_d   = v_fall;
        if (v_fall) begin
            frame_height_d     = line_cnt_eff;
            frame_width_d      = ref_width_eff;
            frame_consistent_d = ~inconsistent_eff;
            line_cnt_d         = '0;
            ref_valid_d        = 1'b0;
            ref_width_d        = '0;
            inconsistent_d     = 1'b0;
        end

        wr_en_d            = pix_write;
        wr_x_d             = x_base;
        wr_index_d         = index_eff;
        wr_red_d           = red_s1_q;
        wr_green_d         = green_s1_q;
        wr_blue_d          = blue_s1_q;
        line_done_d        = line_close;
        line_width_d       = line_close ? x_q : line_width_q;
        frame_done_d       = v_fall;
        width_overflow_d   = width_overflow_q | (pix_active & x_full);
    end

    assign frame_ok    = frame_consistent_q && (frame_height_q != '0);
    assign frame_match = frame_ok && (frame_height_q == stored_height_q) && (frame_width_q == stored_width_q);
    assign match_inc   = match_cnt_q + C_MATCH_ONE;

    // Lock FSM evaluated on the registered frame summary, so locked moves the cycle after frame_done
    always_comb begin
        state_d         = state_q;
        match_cnt_d     = match_cnt_q;
        stored_width_d  = stored_width_q;
        stored_height_d = stored_height_q;
        if (frame_done_q) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (frame_ok) begin
                        stored_width_d  = frame_width_q;
                        stored_height_d = frame_height_q;
                        match_cnt_d     = C_MATCH_ONE;
                        state_d         = (C_LOCK_FRAMES <= 1) ? ST_LOCKED : ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (frame_match) begin
                        match_cnt_d = match_inc;
                        if (match_inc >= C_MATCH_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        stored_width_d  = frame_width_q;
                        stored_height_d = frame_height_q;
                        match_cnt_d     = C_MATCH_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_match) begin
                        state_d     = ST_UNLOCKED;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // All state registers; stage-1 blanks reset high so nothing is written straight out of reset
    always_ff @(posedge pixel_clk_a) begin
        if (rst) begin
            hsync_s1_q <= 1'b0;  vsync_s1_q <= 1'b0;
            hblank_s1_q <= 1'b1; vblank_s1_q <= 1'b1;
            red_s1_q <= '0;      green_s1_q <= '0;      blue_s1_q <= '0;
            hsync_hist_q <= 1'b0; vsync_hist_q <= 1'b0;
            x_q <= '0;           line_cnt_q <= '0;      index_q <= '0;
            index_rst_pend_q <= 1'b0;
            ref_width_q <= '0;   ref_valid_q <= 1'b0;   inconsistent_q <= 1'b0;
            frame_width_q <= '0; frame_consistent_q <= 1'b0;
            state_q <= ST_UNLOCKED; match_cnt_q <= '0;
            stored_width_q <= '0; stored_height_q <= '0;
            wr_en_q <= 1'b0;     wr_x_q <= '0;          wr_index_q <= '0;
            wr_red_q <= '0;      wr_green_q <= '0;      wr_blue_q <= '0;
            line_done_q <= 1'b0; line_width_q <= '0;
            frame_done_q <= 1'b0; frame_height_q <= '0;
            locked_q <= 1'b0;    width_overflow_q <= 1'b0;
        end else begin
            hsync_s1_q <= hsync_s1_d;   vsync_s1_q <= vsync_s1_d;
            hblank_s1_q <= hblank_s1_d; vblank_s1_q <= vblank_s1_d;
            red_s1_q <= red_s1_d;       green_s1_q <= green_s1_d; blue_s1_q <= blue_s1_d;
            hsync_hist_q <= hsync_hist_d; vsync_hist_q <= vsync_hist_d;
            x_q <= x_d;                 line_cnt_q <= line_cnt_d; index_q <= index_d;
            index_rst_pend_q <= index_rst_pend_d;
            ref_width_q <= ref_width_d; ref_valid_q <= ref_valid_d; inconsistent_q <= inconsistent_d;
            frame_width_q <= frame_width_d; frame_consistent_q <= frame_consistent_d;
            state_q <= state_d;         match_cnt_q <= match_cnt_d;
            stored_width_q <= stored_width_d; stored_height_q <= stored_height_d;
            wr_en_q <= wr_en_d;         wr_x_q <= wr_x_d;         wr_index_q <= wr_index_d;
            wr_red_q <= wr_red_d;       wr_green_q <= wr_green_d; wr_blue_q <= wr_blue_d;
            line_done_q <= line_done_d; line_width_q <= line_width_d;
            frame_done_q <= frame_done_d; frame_height_q <= frame_height_d;
            locked_q <= locked_d;       width_overflow_q <= width_overflow_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_x           = wr_x_q;
    assign wr_index       = wr_index_q;
    assign wr_red         = wr_red_q;
    assign wr_green       = wr_green_q;
    assign wr_blue        = wr_blue_q;
    assign line_done      = line_done_q;
    assign line_width     = line_width_q;
    assign frame_done     = frame_done_q;
    assign frame_height   = frame_height_q;
    assign locked         = locked_q;
    assign width_overflow = width_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_video_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_input_framer
// Description : Self-checking bench for video_input_framer (line table,
//               write/line/frame scoreboards, lock, overflow and reset cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_input_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        hsync = 0, vsync = 0, hblank = 1, vblank = 1;
    logic [7:0]  red = 0, green = 0, blue = 0;
    logic        wr_en, line_done, frame_done, locked, width_overflow;
    logic [10:0] wr_x, line_width;
    logic [2:0]  wr_index;
    logic [7:0]  wr_red, wr_green, wr_blue;
    logic [9:0]  frame_height;

    video_input_framer dut (
        .pixel_clk_a(clk), .rst(rst),
        .hsync_a(hsync), .vsync_a(vsync), .hblank_a(hblank), .vblank_a(vblank),
        .red_a(red), .green_a(green), .blue_a(blue),
        .wr_en(wr_en), .wr_x(wr_x), .wr_index(wr_index),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
        .line_done(line_done), .line_width(line_width),
        .frame_done(frame_done), .frame_height(frame_height),
        .locked(locked), .width_overflow(width_overflow)
    );

    // Narrow-x instance for the width overflow case
    logic        ov_hsync = 0, ov_vsync = 0, ov_hblank = 1, ov_vblank = 1;
    logic [7:0]  ov_pix = 8'h5a;
    logic        ov_wr_en, ov_line_done, ov_frame_done, ov_locked, ov_width_overflow;
    logic [3:0]  ov_wr_x, ov_line_width;
    logic [2:0]  ov_wr_index;
    logic [7:0]  ov_wr_red, ov_wr_green, ov_wr_blue;
    logic [9:0]  ov_frame_height;

    video_input_framer #(.C_X_WIDTH(4)) dut_ov (
        .pixel_clk_a(clk), .rst(rst),
        .hsync_a(ov_hsync), .vsync_a(ov_vsync), .hblank_a(ov_hblank), .vblank_a(ov_vblank),
        .red_a(ov_pix), .green_a(ov_pix), .blue_a(ov_pix),
        .wr_en(ov_wr_en), .wr_x(ov_wr_x), .wr_index(ov_wr_index),
        .wr_red(ov_wr_red), .wr_green(ov_wr_green), .wr_blue(ov_wr_blue),
        .line_done(ov_line_done), .line_width(ov_line_width),
        .frame_done(ov_frame_done), .frame_height(ov_frame_height),
        .locked(ov_locked), .width_overflow(ov_width_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Scoreboards
    typedef struct {
        int          x;
        int          idx;
        logic [23:0] rgb;
        int          at;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    int      ld_q[$];
    int      fd_q[$];
    bit      sb_en = 1'b1;
    wr_exp_t mon_e;
    int      mon_v;
    int      ov_exp_x = 0;
    int      ov_ld_cnt = 0;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && sb_en) begin
                if (wr_q.size() == 0) unexpected("wr_en");
                else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_x", wr_x, mon_e.x);
                    chk("wr_index", wr_index, mon_e.idx);
                    chk("wr_rgb", {wr_red, wr_green, wr_blue}, mon_e.rgb);
                    chk("wr_cycle", cyc, mon_e.at);
                end
            end
            if (line_done) begin
                if (ld_q.size() == 0) unexpected("line_done");
                else begin
                    mon_v = ld_q.pop_front();
                    chk("line_width", line_width, mon_v);
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) unexpected("frame_done");
                else begin
                    mon_v = fd_q.pop_front();
                    chk("frame_height", frame_height, mon_v);
                end
            end
            if (ov_wr_en) begin
                chk("ov_wr_x", ov_wr_x, ov_exp_x);
                ov_exp_x++;
            end
            if (ov_line_done) ov_ld_cnt++;
        end
    end

    // Stimulus helpers (main instance)
    task automatic drive(input bit hs, input bit vs, input bit hb, input bit vb, input logic [23:0] px);
        @(negedge clk);
        hsync = hs; vsync = vs; hblank = hb; vblank = vb;
        {red, green, blue} = px;
    endtask

    task automatic pixel(input bit hs, input int x, input int idx);
        logic [23:0] px;
        wr_exp_t     e;
        px = 24'($urandom());
        drive(hs, 1'b0, 1'b0, 1'b0, px);
        if (sb_en) begin
            e.x = x; e.idx = idx; e.rgb = px; e.at = cyc + 2;
            wr_q.push_back(e);
        end
    endtask

    task automatic line_end(input int width);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        if (width > 0) ld_q.push_back(width);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
    endtask

    task automatic do_line(input int n, input int idx, input int width);
        for (int i = 0; i < n; i++) pixel(1'b0, i, idx);
        line_end(width);
    endtask

    task automatic frame_end(input int height);
        fd_q.push_back(height);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 1, 0);
        repeat (5) drive(0, 0, 1, 1, 0);
    endtask

    task automatic ov_drive(input bit hs, input bit hb);
        @(negedge clk);
        ov_hsync = hs; ov_hblank = hb; ov_vblank = 1'b0;
    endtask

    typedef struct {
        int n;
        int idx;
        int width;
    } line_vec_t;

    line_vec_t tbl[11];

    initial begin
        // Line table: pixels per line, index its pixels go to, expected line_done width (0: none)
        tbl[0]  = '{320, 0, 320};
        tbl[1]  = '{320, 1, 320};
        tbl[2]  = '{320, 2, 320};
        tbl[3]  = '{0,   0, 0};
        tbl[4]  = '{5,   3, 5};
        tbl[5]  = '{7,   4, 7};
        tbl[6]  = '{3,   5, 3};
        tbl[7]  = '{0,   0, 0};
        tbl[8]  = '{9,   6, 9};
        tbl[9]  = '{4,   7, 4};
        tbl[10] = '{6,   0, 6};

        // Reset state
        repeat (3) drive(0, 0, 1, 1, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", width_overflow, 0);
        chk("rst_wr_index", wr_index, 0);
        rst = 1'b0;
        repeat (2) drive(0, 0, 1, 1, 0);

        // Table-driven frame: widths, blank lines and index wrap
        for (int i = 0; i < 11; i++) do_line(tbl[i].n, tbl[i].idx, tbl[i].width);
        frame_end(9);
        chk("locked_after_mixed_frame", locked, 0);

        // Lock acquisition over identical frames, loss on a short line
        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < 16; l++) begin
                int w;
                w = (f == 3 && l == 5) ? 23 : 24;
                do_line(w, l % 8, w);
            end
            frame_end(16);
            chk($sformatf("locked_after_frame_%0d", f), locked, (f == 1 || f == 2) ? 1 : 0);
        end

        // Overflow on the 4-bit-x instance: 20 active pixels
        for (int i = 0; i < 20; i++) ov_drive(0, 0);
        ov_drive(0, 1); ov_drive(1, 1); ov_drive(1, 1);
        repeat (4) ov_drive(0, 1);
        chk("ov_writes", ov_exp_x, 15);
        chk("ov_line_done_count", ov_ld_cnt, 1);
        chk("ov_line_width", ov_line_width, 15);
        chk("ov_overflow_set", ov_width_overflow, 1);
        repeat (10) drive(0, 0, 1, 1, 0);
        chk("ov_overflow_sticky", ov_width_overflow, 1);

        // Reset mid-line: partial line discarded, everything cleared
        repeat (2) drive(0, 0, 1, 0, 0);
        sb_en = 1'b0;
        for (int i = 0; i < 10; i++) pixel(1'b0, i, 0);
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_x", wr_x, 0);
        chk("mid_rst_line_width", line_width, 0);
        chk("mid_rst_frame_height", frame_height, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_ov_overflow", ov_width_overflow, 0);
        chk("mid_rst_ov_line_width", ov_line_width, 0);
        rst = 1'b0;
        repeat (3) drive(0, 0, 1, 0, 0);
        sb_en = 1'b1;
        line_end(0);
        do_line(30, 0, 30);

        // hsync falls on an active pixel: old line closes, pixel starts the next one
        for (int i = 0; i < 4; i++) pixel(1'b0, i, 1);
        pixel(1'b1, 4, 1);
        pixel(1'b1, 5, 1);
        ld_q.push_back(6);
        pixel(1'b0, 0, 2);
        for (int i = 1; i < 5; i++) pixel(1'b0, i, 2);
        line_end(5);

        repeat (6) drive(0, 0, 1, 1, 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("line_queue_drained", ld_q.size(), 0);
        chk("frame_queue_drained", fd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
